// File: rtl/seg_pkg.sv
// Constants shared by the 7-segment scan controller and its decoder.
package seg_pkg;
    localparam int unsigned NIB_W     = 4;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
endpackage

// File: rtl/bcd7seg.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module bcd7seg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] hex_i,
    output logic [6:0]       seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with a frame-synchronous,
// double-buffered write port so a new value never tears mid-frame.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NDIG  = 8,
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [NIB_W*NDIG-1:0] wr_data,
    input  logic [NDIG-1:0]       wr_en,
    input  logic                  lzb_en,
    output logic [6:0]            seg,
    output logic [NDIG-1:0]       an
);
    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned IW = $clog2(NDIG);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pfull_q, pfull_d;
    logic [NIB_W*NDIG-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [NDIG-1:0]       pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic                  pend_lzb_q, pend_lzb_d, act_lzb_q, act_lzb_d;
    logic [6:0]            seg_q, seg_d;
    logic [NDIG-1:0]       an_q, an_d;

    logic                  tick, last_idx, frame, accept;
    logic [NDIG-1:0]       nz_above, vis;
    logic [NIB_W-1:0]      cur_nib;
    logic [6:0]            dec_seg;

    assign wr_ready = !pfull_q;
    assign accept   = wr_valid && !pfull_q;
    assign tick     = (pcnt_q == PW'(DIV - 1));
    assign last_idx = (idx_q == IW'(NDIG - 1));
    assign frame    = tick && last_idx;

    // Prefix-OR from the MSB down: bit k set if any nibble at or above k is nonzero.
    always_comb begin
        nz_above = '0;
        vis      = '0;
        nz_above[NDIG-1] = |act_data_q[NIB_W*(NDIG-1) +: NIB_W];
        for (int k = NDIG - 2; k >= 0; k--)
            nz_above[k] = nz_above[k+1] | (|act_data_q[NIB_W*k +: NIB_W]);
        for (int k = 0; k < NDIG; k++)
            vis[k] = act_en_q[k] && (!act_lzb_q || k == 0 || nz_above[k]);
    end

    always_comb begin
        cur_nib = act_data_q[int'(idx_q)*NIB_W +: NIB_W];
    end

    bcd7seg u_dec (
        .hex_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        pcnt_d      = tick ? '0 : pcnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick)
            idx_d = last_idx ? '0 : idx_q + 1'b1;

        pfull_d     = pfull_q;
        pend_data_d = pend_data_q;
        pend_en_d   = pend_en_q;
        pend_lzb_d  = pend_lzb_q;
        act_data_d  = act_data_q;
        act_en_d    = act_en_q;
        act_lzb_d   = act_lzb_q;

        // A full pending buffer blocks acceptance, so promote and accept never collide.
        if (frame && pfull_q) begin
            act_data_d = pend_data_q;
            act_en_d   = pend_en_q;
            act_lzb_d  = pend_lzb_q;
            pfull_d    = 1'b0;
        end else if (accept) begin
            pend_data_d = wr_data;
            pend_en_d   = wr_en;
            pend_lzb_d  = lzb_en;
            pfull_d     = 1'b1;
        end

        if (pcnt_q < PW'(BLANK) || !vis[idx_q]) begin
            seg_d = SEG_BLANK;
            an_d  = '1;
        end else begin
            seg_d = dec_seg;
            an_d  = ~(NDIG'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            pfull_q     <= 1'b0;
            pend_data_q <= '0;
            pend_en_q   <= '0;
            pend_lzb_q  <= 1'b0;
            act_data_q  <= '0;
            act_en_q    <= '0;
            act_lzb_q   <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            pfull_q     <= pfull_d;
            pend_data_q <= pend_data_d;
            pend_en_q   <= pend_en_d;
            pend_lzb_q  <= pend_lzb_d;
            act_data_q  <= act_data_d;
            act_en_q    <= act_en_d;
            act_lzb_q   <= act_lzb_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
endmodule
